serial_add_ctrl: RTL and testbench

Bit-serial adder sequencer built around a single 1-bit full-adder cell (sum = a^b^c, carry = majority). Accepts two WIDTH-bit operands plus carry-in on a start strobe, then feeds them LSB-first through the cell over WIDTH cycles. It holds the running carry in a register and assembles the WIDTH-bit result plus carry-out. It sits between the tile pin wrapper and the adder cell, replacing the parallel ripple chain with one shared cell.

---
 rtl/serial_add_ctrl.sv | 138 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer around one shared 1-bit full-adder cell.
// Operands are captured on an accepted start, then fed LSB-first through the cell
// over WIDTH enabled cycles; the running carry lives in a register and the result
// is assembled in a right-shifting register, published to sum/cout on the last bit.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a 'sub' input (a - b, cout = no borrow).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned  CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sr_q, a_sr_d;
    logic [WIDTH-1:0]  b_sr_q, b_sr_d;
    logic [WIDTH-1:0]  res_sr_q, res_sr_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic [WIDTH-1:0]  b_cap;
    logic              carry_cap;
    logic              fa_sum;
    logic              fa_carry;

    // Operand conditioning at capture: subtraction is a + ~b + 1
`ifdef SERIAL_ADD_SUB_EN
    always_comb begin
        b_cap     = sub ? ~b : b;
        carry_cap = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_cap     = b;
        carry_cap = cin;
    end
`endif

    // The shared 1-bit full-adder cell
    always_comb begin
        fa_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        fa_carry = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    end

    // Next-state and datapath update; defaults hold every register
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b_cap;
                    carry_d  = carry_cap;
                    res_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = {fa_sum, res_sr_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; en=0 freezes everything, reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else if (en) begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    // Status decode straight from the state register
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed and random operations
// compared against a plain-arithmetic reference (a + b + cin, or a - b when subtracting).
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation from the request edge to the done pulse.
    // repulse_at: RUN cycle index at which a stray start is presented (-1 = none)
    // stall_at  : RUN cycle index at which en drops for 3 cycles (-1 = none);
    //             also stretches done for 2 disabled cycles
    // chain     : leave right after the done check so the caller can start back-to-back
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         input logic osub, input int repulse_at, input int stall_at,
                         input bit chain);
        logic [W:0]   ref_full;
        logic [W-1:0] held_sum;
        logic         held_cout;
        if (osub) ref_full = {1'b0, oa} + {1'b0, ~ob} + (W+1)'(1);
        else      ref_full = {1'b0, oa} + {1'b0, ob} + (W+1)'(oc);
        held_sum  = exp_sum;
        held_cout = exp_cout;

        a = oa; b = ob; cin = oc; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = osub;
`endif
        step();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);

        for (int i = 0; i < int'(W); i++) begin
            chk("busy_run", 16'(busy), 16'd1);
            chk("done_run", 16'(done), 16'd0);
            chk("sum_held", {7'd0, held_cout, held_sum}, {7'd0, cout, sum});
            if (i == repulse_at) begin
                start = 1'b1; a = 8'h01; b = 8'h01;
            end
            if (i == stall_at) begin
                en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    chk("busy_stall", 16'(busy), 16'd1);
                    chk("done_stall", 16'(done), 16'd0);
                end
                en = 1'b1;
            end
            step();
            start = 1'b0;
        end

        exp_sum  = ref_full[W-1:0];
        exp_cout = ref_full[W];
        chk("done_pulse", 16'(done), 16'd1);
        chk("busy_done", 16'(busy), 16'd0);
        chk("sum", 16'(sum), 16'(exp_sum));
        chk("cout", 16'(cout), 16'(exp_cout));

        if (stall_at >= 0) begin
            en = 1'b0;
            for (int s = 0; s < 2; s++) begin
                step();
                chk("done_stretch", 16'(done), 16'd1);
            end
            en = 1'b1;
        end

        if (!chain) begin
            step();
            chk("done_drop", 16'(done), 16'd0);
            chk("busy_idle", 16'(busy), 16'd0);
            chk("sum_keep", 16'(sum), 16'(exp_sum));
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_sum",  16'(sum),  16'd0);
        chk("rst_cout", 16'(cout), 16'd0);
        step();
        rst_n = 1'b1;
        step();

        // Directed additions
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, -1, -1, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, -1, -1, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, -1, -1, 1'b0);

        // Stray start during RUN is ignored
        do_op(8'h10, 8'h20, 1'b0, 1'b0, 3, -1, 1'b0);
        chk("repulse_sum", 16'(sum), 16'h0030);

        // Back-to-back: start presented in DONE begins the next RUN immediately
        do_op(8'h81, 8'h7F, 1'b0, 1'b0, -1, -1, 1'b1);
        do_op(8'h33, 8'h44, 1'b1, 1'b0, -1, -1, 1'b0);

        // en low mid-RUN delays done by the stall length; done stretches while disabled
        do_op(8'hC3, 8'h5E, 1'b1, 1'b0, -1, 4, 1'b0);

        // Reset mid-RUN: outputs clear immediately, no done follows
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_done", 16'(done), 16'd0);
        chk("abort_sum",  16'(sum),  16'd0);
        chk("abort_cout", 16'(cout), 16'd0);
        exp_sum = '0; exp_cout = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < int'(W) + 2; i++) begin
            step();
            chk("abort_nodone", 16'(done), 16'd0);
            chk("abort_idle", 16'(busy), 16'd0);
        end
        do_op(8'h12, 8'h34, 1'b0, 1'b0, -1, -1, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'h10, 8'h01, 1'b0, 1'b1, -1, -1, 1'b0);
        chk("sub_sum1", {7'd0, cout, sum}, 16'h010F);
        do_op(8'h00, 8'h01, 1'b1, 1'b1, -1, -1, 1'b0);
        chk("sub_sum2", {7'd0, cout, sum}, 16'h00FF);
`endif

        // Random operations, some chained back-to-back
        for (int r = 0; r < 24; r++) begin
            logic os;
`ifdef SERIAL_ADD_SUB_EN
            os = 1'($urandom);
`else
            os = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom), 1'($urandom), os,
                  -1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W-1)) : -1,
                  1'($urandom) && (r != 23));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
